// File: rtl/robot_pkg.sv
// rtl/robot_pkg.sv - shared encodings for the wall-following robot controller
// Purpose: direction and cell-code encodings, default grid size, FSM states.
// Ports: none (package).
package robot_pkg;

  localparam int DEF_GRID_COLS = 20;
  localparam int DEF_GRID_ROWS = 15;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  localparam logic [1:0] CELL_FREE = 2'b00;
  localparam logic [1:0] CELL_WALL = 2'b01;
  localparam logic [1:0] CELL_DIRT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_L  = 3'd1,
    ST_EVAL_L = 3'd2,
    ST_REQ_F  = 3'd3,
    ST_EVAL_F = 3'd4,
    ST_ACT    = 3'd5
  } state_t;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - enable-gated wrap counter producing the action tick
// Purpose: counts 0..TICK_CYCLES-1 while enable=1 and wraps; holds while enable=0.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   enable in  1 = count, 0 = hold
//   tick   out high in the last count cycle while enabled
module tick_gen #(
  parameter int TICK_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/robot_controller.sv
// rtl/robot_controller.sv - left-wall-following mover for the pipe-cleaning robot
// Purpose: once per tick probes the left cell, then (if blocked) the front cell,
//   through a 1-cycle-latency map port, and turns left+moves, moves, or turns right.
// Ports:
//   clock_50     in   system clock
//   reset_key    in   asynchronous active-low reset
//   enable       in   1 = tick counter runs
//   map_rd       out  one-cycle map read strobe
//   map_col/row  out  cell being read (held while map_rd=0)
//   map_data     in   cell code, valid the cycle after map_rd
//   robot_col/row/dir out  registered robot pose
//   clean_pulse  out  1-cycle pulse when a dirt cell is entered
//   step_count   out  saturating move counter
module robot_controller
  import robot_pkg::*;
#(
  parameter int         TICK_CYCLES = 12_500_000,
  parameter int         GRID_COLS   = DEF_GRID_COLS,
  parameter int         GRID_ROWS   = DEF_GRID_ROWS,
  parameter int         START_COL   = 1,
  parameter int         START_ROW   = 1,
  parameter logic [1:0] START_DIR   = 2'd1
) (
  input  logic        clock_50,
  input  logic        reset_key,
  input  logic        enable,
  output logic        map_rd,
  output logic [4:0]  map_col,
  output logic [3:0]  map_row,
  input  logic [1:0]  map_data,
  output logic [4:0]  robot_col,
  output logic [3:0]  robot_row,
  output logic [1:0]  robot_dir,
  output logic        clean_pulse,
  output logic [15:0] step_count
);

  state_t state, state_nxt;
  logic tick;

  tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick_gen (
    .clk    (clock_50),
    .rst_n  (reset_key),
    .enable (enable),
    .tick   (tick)
  );

  // Neighbour in the probe direction: left of heading while leaving IDLE,
  // straight ahead while leaving EVAL_L (the only two states that load a probe).
  logic [1:0] probe_dir;
  logic [4:0] nb_col;
  logic [3:0] nb_row;
  logic       nb_ok;

  always_comb begin
    probe_dir = (state == ST_IDLE) ? robot_dir - 2'd1 : robot_dir;
    nb_col    = robot_col;
    nb_row    = robot_row;
    nb_ok     = 1'b0;
    case (probe_dir)
      DIR_N: begin
        nb_ok  = (robot_row != 4'd0);
        nb_row = robot_row - 4'd1;
      end
      DIR_E: begin
        nb_ok  = (robot_col < 5'(GRID_COLS - 1));
        nb_col = robot_col + 5'd1;
      end
      DIR_S: begin
        nb_ok  = (robot_row < 4'(GRID_ROWS - 1));
        nb_row = robot_row + 4'd1;
      end
      default: begin
        nb_ok  = (robot_col != 5'd0);
        nb_col = robot_col - 5'd1;
      end
    endcase
  end

  // probe_ok remembers whether the cell being evaluated was inside the grid;
  // an out-of-grid probe is a wall regardless of what map_data carries.
  logic probe_ok;
  logic passable;
  assign passable = probe_ok && ((map_data == CELL_FREE) || (map_data == CELL_DIRT));

  logic load_probe, do_move, turn_left, turn_right;

  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_probe = 1'b0;
    do_move    = 1'b0;
    turn_left  = 1'b0;
    turn_right = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick) begin
          state_nxt  = ST_REQ_L;
          load_probe = 1'b1;
        end
      end
      ST_REQ_L:  state_nxt = ST_EVAL_L;
      ST_EVAL_L: begin
        if (passable) begin
          do_move   = 1'b1;
          turn_left = 1'b1;
          state_nxt = ST_ACT;
        end else begin
          load_probe = 1'b1;
          state_nxt  = ST_REQ_F;
        end
      end
      ST_REQ_F:  state_nxt = ST_EVAL_F;
      ST_EVAL_F: begin
        if (passable) do_move    = 1'b1;
        else          turn_right = 1'b1;
        state_nxt = ST_ACT;
      end
      ST_ACT:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Pose registers load on the edge into ACT, so the new pose is visible
  // during ACT: 3 cycles after the tick for a left move, 5 otherwise.
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      map_rd      <= 1'b0;
      map_col     <= '0;
      map_row     <= '0;
      probe_ok    <= 1'b0;
      robot_col   <= 5'(START_COL);
      robot_row   <= 4'(START_ROW);
      robot_dir   <= START_DIR;
      clean_pulse <= 1'b0;
      step_count  <= '0;
    end else begin
      map_rd      <= load_probe && nb_ok;
      clean_pulse <= do_move && (map_data == CELL_DIRT);
      if (load_probe) begin
        probe_ok <= nb_ok;
        if (nb_ok) begin
          map_col <= nb_col;
          map_row <= nb_row;
        end
      end
      // map_col/map_row still hold the probed (in-grid) target when moving.
      if (do_move) begin
        robot_col <= map_col;
        robot_row <= map_row;
        if (step_count != 16'hFFFF) step_count <= step_count + 16'd1;
      end
      if (turn_left)       robot_dir <= robot_dir - 2'd1;
      else if (turn_right) robot_dir <= robot_dir + 2'd1;
    end
  end

endmodule

// File: tb/tb_robot_controller.sv
// tb/tb_robot_controller.sv - self-checking bench for robot_controller
module tb_robot_controller;

  localparam int COLS = 20;
  localparam int ROWS = 15;

  logic clk = 1'b0;
  logic rst1_n, rst2_n, en;
  logic [1:0] grid [0:ROWS-1][0:COLS-1];

  logic rd1, rd2, cp1, cp2;
  logic [4:0] mc1, mc2, rc1, rc2;
  logic [3:0] mr1, mr2, rr1, rr2;
  logic [1:0] md1, md2, dir1, dir2;
  logic [15:0] sc1, sc2;

  int tests = 0;
  int fails = 0;
  bit sel = 1'b0;

  always #5 clk = ~clk;

  robot_controller #(.TICK_CYCLES(8), .GRID_COLS(COLS), .GRID_ROWS(ROWS),
                     .START_COL(1), .START_ROW(1), .START_DIR(2'd1)) dut1 (
    .clock_50(clk), .reset_key(rst1_n), .enable(en), .map_rd(rd1), .map_col(mc1),
    .map_row(mr1), .map_data(md1), .robot_col(rc1), .robot_row(rr1), .robot_dir(dir1),
    .clean_pulse(cp1), .step_count(sc1));

  robot_controller #(.TICK_CYCLES(8), .GRID_COLS(COLS), .GRID_ROWS(ROWS),
                     .START_COL(0), .START_ROW(0), .START_DIR(2'd0)) dut2 (
    .clock_50(clk), .reset_key(rst2_n), .enable(en), .map_rd(rd2), .map_col(mc2),
    .map_row(mr2), .map_data(md2), .robot_col(rc2), .robot_row(rr2), .robot_dir(dir2),
    .clean_pulse(cp2), .step_count(sc2));

  // Map memories: 1-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    if (rd1) md1 <= grid[mr1][mc1]; else md1 <= 2'($urandom);
    if (rd2) md2 <= grid[mr2][mc2]; else md2 <= 2'($urandom);
  end

  logic o_rd, o_cp;
  logic [4:0] o_mc, o_rc;
  logic [3:0] o_mr, o_rr;
  logic [1:0] o_dir;
  logic [15:0] o_sc;
  always_comb begin
    o_rd  = sel ? rd2  : rd1;
    o_mc  = sel ? mc2  : mc1;
    o_mr  = sel ? mr2  : mr1;
    o_rc  = sel ? rc2  : rc1;
    o_rr  = sel ? rr2  : rr1;
    o_dir = sel ? dir2 : dir1;
    o_cp  = sel ? cp2  : cp1;
    o_sc  = sel ? sc2  : sc1;
  end

  // Reference pose of the observed robot.
  int mcol, mrow, mdir, msteps;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pose(input string tag, input int c, input int r, input int d, input int s);
    chk({tag, ".col"}, 32'(o_rc), c);
    chk({tag, ".row"}, 32'(o_rr), r);
    chk({tag, ".dir"}, 32'(o_dir), d);
    chk({tag, ".steps"}, 32'(o_sc), s);
  endtask

  function automatic void nbr(input int c, input int r, input int d,
                              output int nc, output int nr, output bit ok);
    nc = c + ((d == 1) ? 1 : (d == 3) ? -1 : 0);
    nr = r + ((d == 2) ? 1 : (d == 0) ? -1 : 0);
    ok = (nc >= 0) && (nc < COLS) && (nr >= 0) && (nr < ROWS);
  endfunction

  function automatic bit cell_pass(input int c, input int r, input bit ok);
    if (!ok) return 1'b0;
    return (grid[r][c] == 2'b00) || (grid[r][c] == 2'b10);
  endfunction

  task automatic clear_grid();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) grid[r][c] = 2'b00;
  endtask

  task automatic rand_grid();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        int x;
        x = $urandom_range(0, 9);
        grid[r][c] = (x < 6) ? 2'b00 : (x < 8) ? 2'b10 : (x < 9) ? 2'b01 : 2'b11;
      end
  endtask

  // Resets both DUTs; leaves the bench at the negedge of the first tick cycle.
  task automatic do_reset();
    int sc, sr, sd;
    sc = sel ? 0 : 1; sr = sel ? 0 : 1; sd = sel ? 0 : 1;
    @(negedge clk);
    rst1_n = 1'b0; rst2_n = 1'b0;
    #1;
    chk_pose("reset", sc, sr, sd, 0);
    chk("reset.map_rd", 32'(o_rd), 0);
    chk("reset.map_col", 32'(o_mc), 0);
    chk("reset.map_row", 32'(o_mr), 0);
    chk("reset.clean", 32'(o_cp), 0);
    @(negedge clk);
    rst1_n = 1'b1; rst2_n = 1'b1;
    mcol = sc; mrow = sr; mdir = sd; msteps = 0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); @(negedge clk);
      chk("pre_tick.map_rd", 32'(o_rd), 0);
      chk("pre_tick.dir", 32'(o_dir), sd);
    end
  endtask

  // Called at the negedge of a tick cycle; checks the 8 cycles that follow.
  task automatic action_check(input bit drop_en);
    int ldir, lc, lr, fc, fr, ncol, nrow, ndir, lat, nsteps;
    bit lok, fok, lp, fp, moved, dirt, erd;
    ldir = (mdir + 3) % 4;
    nbr(mcol, mrow, ldir, lc, lr, lok);
    nbr(mcol, mrow, mdir, fc, fr, fok);
    lp = cell_pass(lc, lr, lok);
    fp = cell_pass(fc, fr, fok);
    ncol = mcol; nrow = mrow; ndir = mdir; moved = 0; dirt = 0; lat = 5;
    if (lp) begin
      ncol = lc; nrow = lr; ndir = ldir; lat = 3; moved = 1; dirt = (grid[lr][lc] == 2'b10);
    end else if (fp) begin
      ncol = fc; nrow = fr; moved = 1; dirt = (grid[fr][fc] == 2'b10);
    end else begin
      ndir = (mdir + 1) % 4;
    end
    nsteps = (moved && msteps < 65535) ? msteps + 1 : msteps;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); @(negedge clk);
      if (drop_en && k == 1) en = 1'b0;
      erd = (k == 1 && lok) || (k == 3 && !lp && fok);
      chk("map_rd", 32'(o_rd), 32'(erd));
      if (k == 1 && lok) begin
        chk("left.col", 32'(o_mc), lc); chk("left.row", 32'(o_mr), lr);
      end
      if (k == 3 && erd) begin
        chk("front.col", 32'(o_mc), fc); chk("front.row", 32'(o_mr), fr);
      end
      if (k >= lat) chk_pose("after", ncol, nrow, ndir, nsteps);
      else          chk_pose("before", mcol, mrow, mdir, msteps);
      chk("clean_pulse", 32'(o_cp), 32'(k == lat && dirt));
    end
    mcol = ncol; mrow = nrow; mdir = ndir; msteps = nsteps;
    if (drop_en) begin
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); @(negedge clk);
        chk("disabled.map_rd", 32'(o_rd), 0);
        chk_pose("disabled", mcol, mrow, mdir, msteps);
      end
      en = 1'b1;
      for (int i = 0; i < 7; i++) begin
        @(posedge clk); @(negedge clk);
        chk("reenable.map_rd", 32'(o_rd), 0);
      end
    end
  endtask

  initial begin
    rst1_n = 1'b0; rst2_n = 1'b0; en = 1'b1; sel = 1'b0;
    clear_grid();

    do_reset();
    action_check(0);                      // all free: up to (1,0) N

    do_reset(); grid[0][1] = 2'b01;
    action_check(0);                      // left wall, front free: (2,1) E

    do_reset(); grid[1][2] = 2'b01;
    action_check(0);                      // both blocked: rotate to S

    do_reset(); clear_grid(); grid[0][1] = 2'b10;
    action_check(0);                      // dirt on the left: clean pulse

    do_reset(); rand_grid();
    for (int i = 0; i < 40; i++) begin
      if (i % 10 == 9) rand_grid();
      action_check(i == 7);
    end

    sel = 1'b1; clear_grid();
    do_reset();
    action_check(0);                      // corner (0,0) N: no reads, turn E
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); @(negedge clk);
      chk("corner.map_rd", 32'(o_rd), 32'(k == 3));
      if (k == 3) begin
        chk("corner.front.col", 32'(o_mc), 1); chk("corner.front.row", 32'(o_mr), 0);
      end
    end
    chk("corner.dir_before_reset", 32'(o_dir), 1);
    rst2_n = 1'b0;                        // now in EVAL_F
    #1;
    chk_pose("midreset", 0, 0, 0, 0);
    chk("midreset.map_rd", 32'(o_rd), 0);
    chk("midreset.clean", 32'(o_cp), 0);
    @(negedge clk);
    rst2_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
